// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - async FIFO write-side controller: pointers, full/level flags, drain handshake
// Optional rejected-write counter enabled by `define FIFO_WR_OVF_CNT_EN
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  restn,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
    input  logic                  drain_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  drain_done,
    output logic [7:0]            ovf_cnt
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;
    logic [PW-1:0] full_cmp;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign mem_we     = wr_req & ~full & (state == RUN);
    assign mem_waddr  = wbin[ADDR_WIDTH-1:0];
    assign wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, mem_we};
    assign gray_next  = wbin_next ^ (wbin_next >> 1);
    assign rbin       = gray2bin(rptr_gray_sync);
    // Read pointer is stale by the synchronizer delay, so this over-estimates occupancy.
    assign level_next = wbin_next - rbin;
    // Full when write is exactly one lap ahead: top two Gray bits inverted, rest equal.
    assign full_cmp   = {~rptr_gray_sync[PW-1:PW-2], rptr_gray_sync[PW-3:0]};

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (drain_req) state_next = DRAIN;
            end
            DRAIN: begin
                if (!drain_req)                       state_next = RUN;
                else if (rptr_gray_sync == wptr_gray) state_next = DONE;
            end
            DONE: begin
                if (!drain_req) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge restn) begin
        if (!restn) begin
            state       <= RUN;
            wbin        <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            level       <= '0;
            drain_done  <= 1'b0;
        end else begin
            state       <= state_next;
            wbin        <= wbin_next;
            wptr_gray   <= gray_next;
            full        <= (gray_next == full_cmp);
            almost_full <= (level_next >= AF_THRESH);
            level       <= level_next;
            drain_done  <= (state_next == DONE);
        end
    end

`ifdef FIFO_WR_OVF_CNT_EN
    logic [7:0] ovf_q;

    always_ff @(posedge clk or negedge restn) begin
        if (!restn) begin
            ovf_q <= 8'd0;
        end else if (wr_req && !mem_we && ovf_q != 8'hFF) begin
            ovf_q <= ovf_q + 8'd1;
        end
    end

    assign ovf_cnt = ovf_q;
`else
    assign ovf_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - scoreboard bench for fifo_wr_ctrl (ADDR_WIDTH=4, AF_MARGIN=2)
module tb_fifo_wr_ctrl;

    logic       clk;
    logic       restn;
    logic       wr_req;
    logic [4:0] rptr_gray_sync;
    logic       drain_req;
    logic       mem_we;
    logic [3:0] mem_waddr;
    logic [4:0] wptr_gray;
    logic       full;
    logic       almost_full;
    logic [4:0] level;
    logic       drain_done;
    logic [7:0] ovf_cnt;

    typedef struct {
        int         id;
        logic       we;
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic       full;
        logic       af;
        logic [4:0] level;
        logic       dd;
        logic [7:0] ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;
    int   ovf_exp;
    int   id_ctr;

    fifo_wr_ctrl #(.ADDR_WIDTH(4), .AF_MARGIN(2)) dut (
        .clk            (clk),
        .restn          (restn),
        .wr_req         (wr_req),
        .rptr_gray_sync (rptr_gray_sync),
        .drain_req      (drain_req),
        .mem_we         (mem_we),
        .mem_waddr      (mem_waddr),
        .wptr_gray      (wptr_gray),
        .full           (full),
        .almost_full    (almost_full),
        .level          (level),
        .drain_done     (drain_done),
        .ovf_cnt        (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] g(input int x);
        logic [4:0] b;
        b = 5'(x);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input int id, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL vec=%0d %s actual=%0d expected=%0d", id, name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.id, "mem_we",      int'(mem_we),      int'(e.we));
            chk(e.id, "mem_waddr",   int'(mem_waddr),   int'(e.waddr));
            chk(e.id, "wptr_gray",   int'(wptr_gray),   int'(e.wptr));
            chk(e.id, "full",        int'(full),        int'(e.full));
            chk(e.id, "almost_full", int'(almost_full), int'(e.af));
            chk(e.id, "level",       int'(level),       int'(e.level));
            chk(e.id, "drain_done",  int'(drain_done),  int'(e.dd));
            chk(e.id, "ovf_cnt",     int'(ovf_cnt),     int'(e.ovf));
        end
    end

    task automatic push(input logic wr, input logic e_we, input int e_waddr, input logic [4:0] e_wptr,
                        input logic e_full, input logic e_af, input int e_level, input logic e_dd);
        exp_t e;
        e.id    = id_ctr;
        e.we    = e_we;
        e.waddr = 4'(e_waddr);
        e.wptr  = e_wptr;
        e.full  = e_full;
        e.af    = e_af;
        e.level = 5'(e_level);
        e.dd    = e_dd;
        e.ovf   = 8'(ovf_exp);
        exp_q.push_back(e);
        id_ctr++;
`ifdef FIFO_WR_OVF_CNT_EN
        if (wr && !e_we && ovf_exp < 255) ovf_exp++;
`else
        if (wr && !e_we) ovf_exp = ovf_exp;
`endif
    endtask

    task automatic step(input logic wr, input logic drn, input logic [4:0] rptr,
                        input logic e_we, input int e_waddr, input logic [4:0] e_wptr,
                        input logic e_full, input logic e_af, input int e_level, input logic e_dd);
        @(posedge clk);
        #1;
        wr_req         = wr;
        drain_req      = drn;
        rptr_gray_sync = rptr;
        push(wr, e_we, e_waddr, e_wptr, e_full, e_af, e_level, e_dd);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        restn          = 1'b0;
        wr_req         = 1'b0;
        drain_req      = 1'b0;
        rptr_gray_sync = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        restn   = 1'b1;
        ovf_exp = 0;
    endtask

    task automatic fill16();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 5'd0, 1'b1, i, g(i), 1'b0, (i >= 14), i, 1'b0);
        end
    endtask

    initial begin
        checks = 0; failures = 0; ovf_exp = 0; id_ctr = 0;
        restn = 1'b0; wr_req = 1'b0; drain_req = 1'b0; rptr_gray_sync = 5'd0;

        // Reset then idle
        do_reset();
        step(1'b0, 1'b0, 5'd0, 1'b0, 0, 5'd0, 1'b0, 1'b0, 0, 1'b0);

        // Write to full, then a rejected 17th request
        fill16();
        step(1'b1, 1'b0, 5'd0, 1'b0, 0, 5'b11000, 1'b1, 1'b1, 16, 1'b0);

        // Read release: one slot frees, one write, full again
        step(1'b0, 1'b0, 5'b00001, 1'b0, 0, 5'b11000, 1'b1, 1'b1, 16, 1'b0);
        step(1'b1, 1'b0, 5'b00001, 1'b1, 0, 5'b11000, 1'b0, 1'b1, 15, 1'b0);
        step(1'b1, 1'b0, 5'b00001, 1'b0, 1, 5'b11001, 1'b1, 1'b1, 16, 1'b0);

        // Wrap: reader tracks writer, level stays at most 1
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, g(i % 32), 1'b1, i % 16, g(i % 32), 1'b0, 1'b0, (i == 0) ? 0 : 1, 1'b0);
        end
        step(1'b0, 1'b0, g(7), 1'b0, 8, g(8), 1'b0, 1'b0, 1, 1'b0);

        // Drain handshake
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 5'd0, 1'b1, i, g(i), 1'b0, 1'b0, i, 1'b0);
        end
        step(1'b1, 1'b1, 5'd0,     1'b1, 5, 5'b00111, 1'b0, 1'b0, 5, 1'b0);
        step(1'b1, 1'b1, 5'd0,     1'b0, 6, 5'b00101, 1'b0, 1'b0, 6, 1'b0);
        step(1'b0, 1'b1, 5'b00101, 1'b0, 6, 5'b00101, 1'b0, 1'b0, 6, 1'b0);
        step(1'b1, 1'b0, 5'b00101, 1'b0, 6, 5'b00101, 1'b0, 1'b0, 0, 1'b1);
        step(1'b1, 1'b0, 5'b00101, 1'b1, 6, 5'b00101, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 5'b00101, 1'b0, 7, 5'b00100, 1'b0, 1'b0, 1, 1'b0);

        // Async reset while in DRAIN with full set
        do_reset();
        fill16();
        step(1'b0, 1'b1, 5'd0, 1'b0, 0, 5'b11000, 1'b1, 1'b1, 16, 1'b0);
        @(posedge clk);
        #1;
        restn     = 1'b0;
        drain_req = 1'b1;
        ovf_exp   = 0;
        push(1'b0, 1'b0, 0, 5'd0, 1'b0, 1'b0, 0, 1'b0);
        @(posedge clk);
        #1;
        restn     = 1'b1;
        drain_req = 1'b0;
        step(1'b0, 1'b0, 5'd0, 1'b0, 0, 5'd0, 1'b0, 1'b0, 0, 1'b0);

        for (int k = 0; k < 100 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_queue actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
